// File: rtl/vga_box_painter_pkg.sv
// rtl/vga_box_painter_pkg.sv - shared VGA timing constants and box colour table
package vga_box_painter_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int BOX_SIZE_DEF = 32;
    localparam int STEP_DEF     = 2;

    localparam logic [23:0] RGB_RED    = 24'hFF_00_00;
    localparam logic [23:0] RGB_GREEN  = 24'h00_FF_00;
    localparam logic [23:0] RGB_BLUE   = 24'h00_00_FF;
    localparam logic [23:0] RGB_PINK   = 24'hF4_C9_BC;
    localparam logic [23:0] RGB_PURPLE = 24'h76_0F_D4;
    localparam logic [23:0] RGB_WHITE  = 24'hFF_FF_FF;

    // Anything that is not exactly one-hot paints white.
    function automatic logic [23:0] decode_colour(input logic [4:0] sw);
        case (sw)
            5'b10000: decode_colour = RGB_RED;
            5'b01000: decode_colour = RGB_GREEN;
            5'b00100: decode_colour = RGB_BLUE;
            5'b00010: decode_colour = RGB_PINK;
            5'b00001: decode_colour = RGB_PURPLE;
            default:  decode_colour = RGB_WHITE;
        endcase
    endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// rtl/vga_bounce_axis.sv - one axis of the bouncing box: position register and direction flop
module vga_bounce_axis
    import vga_box_painter_pkg::*;
#(
    parameter int LIMIT = H_ACTIVE_DEF,
    parameter int SIZE  = BOX_SIZE_DEF,
    parameter int STEP  = STEP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       pause,
    output logic [9:0] pos,
    output logic       dir
);

    localparam logic [9:0] POS_MAX  = 10'(LIMIT - SIZE);
    localparam logic [9:0] POS_TURN = 10'(LIMIT - SIZE - STEP);
    localparam logic [9:0] STEP_W   = 10'(STEP);

    logic [9:0] pos_q, pos_d;
    logic       dir_q, dir_d;

    // dir = 1 moves towards LIMIT; edges clamp so the unsigned position never wraps.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (tick && !pause) begin
            if (dir_q) begin
                if (pos_q >= POS_TURN) begin
                    pos_d = POS_MAX;
                    dir_d = 1'b0;
                end else begin
                    pos_d = pos_q + STEP_W;
                end
            end else begin
                if (pos_q <= STEP_W) begin
                    pos_d = '0;
                    dir_d = 1'b1;
                end else begin
                    pos_d = pos_q - STEP_W;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
            dir_q <= 1'b1;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos = pos_q;
    assign dir = dir_q;

endmodule

// File: rtl/vga_box_painter.sv
// rtl/vga_box_painter.sv - paints a bouncing solid box over black for the VGA output stage
module vga_box_painter
    import vga_box_painter_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_SIZE = BOX_SIZE_DEF,
    parameter int STEP     = STEP_DEF
) (
    input  logic       VGA_CLK,
    input  logic       Reset,
    input  logic [9:0] hor_counter,
    input  logic [9:0] ver_counter,
    input  logic [4:0] Sw,
    input  logic       Pause,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue
);

    localparam logic [9:0]  H_ACT_W = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT_W = 10'(V_ACTIVE);
    localparam logic [10:0] SIZE_W  = 11'(BOX_SIZE);

    logic [9:0]  box_x, box_y;
    logic        unused_dir_x, unused_dir_y;
    logic        tick;
    logic        active, inbox;
    logic [4:0]  sw_q, sw_d;
    logic [23:0] rgb_q, rgb_d;

    // First blanking line start: all frame state moves here so a frame never tears.
    assign tick = (ver_counter == V_ACT_W) && (hor_counter == 10'd0);

    vga_bounce_axis #(.LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP)) u_axis_x (
        .clk   (VGA_CLK),
        .reset (Reset),
        .tick  (tick),
        .pause (Pause),
        .pos   (box_x),
        .dir   (unused_dir_x)
    );

    vga_bounce_axis #(.LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP)) u_axis_y (
        .clk   (VGA_CLK),
        .reset (Reset),
        .tick  (tick),
        .pause (Pause),
        .pos   (box_y),
        .dir   (unused_dir_y)
    );

    always_comb begin
        sw_d   = tick ? Sw : sw_q;
        active = (hor_counter < H_ACT_W) && (ver_counter < V_ACT_W);
        inbox  = (hor_counter >= box_x) && ({1'b0, hor_counter} < ({1'b0, box_x} + SIZE_W)) &&
                 (ver_counter >= box_y) && ({1'b0, ver_counter} < ({1'b0, box_y} + SIZE_W));
        rgb_d  = (active && inbox) ? decode_colour(sw_q) : 24'd0;
    end

    always_ff @(posedge VGA_CLK or posedge Reset) begin
        if (Reset) begin
            sw_q  <= '0;
            rgb_q <= '0;
        end else begin
            sw_q  <= sw_d;
            rgb_q <= rgb_d;
        end
    end

    assign Red   = rgb_q[23:16];
    assign Green = rgb_q[15:8];
    assign Blue  = rgb_q[7:0];

endmodule
